gate_occupancy_ctrl: RTL and testbench
======================================

Name: gate_occupancy_ctrl

Overview:
Downstream stage of the parking-lot mode FSM. It consumes the 2-bit state code (IDLE/ENTRY/EXIT/ALARM) and sequences the entry and exit barrier gates. It confirms each vehicle crossing with the gate beam sensor and maintains the lot occupancy count. It generates lot_full, which is fed back to the mode FSM.

Parameters:
CAPACITY, 16, number of slots; lot_full when count equals this value
CNT_W, 5, width of the count; must hold CAPACITY
PASS_TIMEOUT, 64, cycles a gate waits open for a crossing before aborting
HOLD_CYCLES, 8, cycles a gate stays open after a confirmed crossing
TMR_W, 7, timer width; must hold max(PASS_TIMEOUT, HOLD_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
state_in  in  2  mode code: 00 IDLE, 01 ENTRY, 10 EXIT, 11 ALARM
car_pass  in  1  single-cycle pulse when the gate beam is broken, already synchronised
entry_gate_open  out  1  entry barrier open command
exit_gate_open  out  1  exit barrier open command
alarm  out  1  lot-full alarm indicator
count  out  CNT_W  current occupancy
lot_full  out  1  count == CAPACITY
busy  out  1  gate sequence in progress; state_in is ignored while busy
timeout_err  out  1  one-cycle pulse when a gate aborts with no crossing

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to G_IDLE; timer = 0; count = 0.
  - All outputs are 0, including lot_full.
  - Reset mid-sequence closes the gate immediately. A partial crossing is discarded.
- All outputs are registered. lot_full and busy are decoded from registered state and count only, with no combinational path from the inputs.
- FSM states: G_IDLE, G_OPEN_IN, G_HOLD_IN, G_OPEN_OUT, G_HOLD_OUT.
- G_IDLE (busy=0, gates closed); state_in is sampled at each edge:
  - ENTRY and count < CAPACITY -> G_OPEN_IN; timer = PASS_TIMEOUT-1.
  - ENTRY and count == CAPACITY -> stay in G_IDLE; alarm=1 for that cycle.
  - EXIT and count > 0 -> G_OPEN_OUT; timer = PASS_TIMEOUT-1.
  - EXIT and count == 0 -> stay in G_IDLE. This is a no-op, not an error; the mode FSM emits EXIT whenever entry mode is low.
  - ALARM -> stay in G_IDLE; alarm=1 for that cycle.
  - IDLE -> no action.
- Latency: a code sampled at edge N asserts its gate open command from the cycle after edge N.
- G_OPEN_IN / G_OPEN_OUT (busy=1, the corresponding gate open=1, timer decrements each cycle):
  - car_pass=1: count is incremented (IN) or decremented (OUT). Move to the matching HOLD state; timer = HOLD_CYCLES-1.
  - car_pass=0 and timer==0: timeout_err pulse for one cycle; back to G_IDLE; count unchanged; gate closes.
  - car_pass and timer==0 in the same cycle: the crossing wins; no timeout_err.
- G_HOLD_IN / G_HOLD_OUT:
  - busy=1; gate stays open; timer decrements; car_pass is ignored.
  - At timer==0 -> G_IDLE; gate closes on the next cycle.
- Gate and HOLD timing:
  - Gate open time in HOLD is exactly HOLD_CYCLES cycles.
  - Gate open time on abort is exactly PASS_TIMEOUT cycles.
  - entry_gate_open and exit_gate_open are never both 1.
- Count arithmetic:
  - Saturating: never exceeds CAPACITY and never wraps below 0.
  - These guards are defensive, since admission checks already prevent either case.
- alarm is also 1 in G_IDLE while state_in==ALARM. It is 0 in all busy states.
- car_pass in G_IDLE is ignored. There is no count change and no error.
- lot_full updates the cycle after the count register reaches or leaves CAPACITY.
- After any sequence, at least one G_IDLE cycle occurs before the next gate opens.

Test Plan:
- Reset, then state_in=01, car_pass pulse 3 cycles after the gate opens -> entry_gate_open high for 4 cycles plus HOLD_CYCLES=8 cycles, count=1, busy falls, timeout_err never asserted.
- 16 entry sequences with crossings (CAPACITY=16) -> count=16, lot_full=1. A 17th state_in=01 -> no gate opens, alarm=1 for each ENTRY cycle, count stays 16.
- Count=2, state_in=10, crossing -> exit_gate_open sequence, count=1, lot_full=0. Repeat at count=0 -> exit gate stays closed, busy stays 0.
- state_in=01 and no car_pass -> entry gate open for exactly 64 cycles, then a single-cycle timeout_err, count unchanged. Second run: car_pass lands on the final timeout cycle -> count increments and no timeout_err.
- Toggle state_in between 01 and 10 every cycle while busy -> state_in is ignored until the sequence ends, and only one gate is ever open.
- rst low mid G_HOLD_IN with count=5 -> gates close and count=0 and busy=0 asynchronously, before the next clock edge. After release, the block accepts a new ENTRY normally.

Source files
------------

// File: rtl/gate_occupancy_ctrl.sv
// gate_occupancy_ctrl: sequences entry/exit barriers from the mode code and tracks lot occupancy
module gate_occupancy_ctrl #(
  parameter int CAPACITY     = 16,
  parameter int CNT_W        = 5,
  parameter int PASS_TIMEOUT = 64,
  parameter int HOLD_CYCLES  = 8,
  parameter int TMR_W        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state_in,
  input  logic             car_pass,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic             alarm,
  output logic [CNT_W-1:0] count,
  output logic             lot_full,
  output logic             busy,
  output logic             timeout_err
);
  typedef enum logic [2:0] {G_IDLE, G_OPEN_IN, G_HOLD_IN, G_OPEN_OUT, G_HOLD_OUT} gstate_t;
  localparam logic [1:0] ST_ENTRY = 2'b01, ST_EXIT = 2'b10, ST_ALARM = 2'b11;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] T_PASS = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] T_HOLD = TMR_W'(HOLD_CYCLES - 1);
  gstate_t state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic alarm_q, alarm_d, tmo_q, tmo_d, full_q, full;
  assign full            = count_q == CAP;
  assign entry_gate_open = state_q == G_OPEN_IN  || state_q == G_HOLD_IN;
  assign exit_gate_open  = state_q == G_OPEN_OUT || state_q == G_HOLD_OUT;
  assign busy            = state_q != G_IDLE;
  assign count           = count_q;
  assign lot_full        = full_q;
  assign alarm           = alarm_q;
  assign timeout_err     = tmo_q;
  // next-state: admission in idle, crossing/abort while open, fixed hold before closing
  always_comb begin
    state_d = state_q;
    timer_d = timer_q - 1'b1;
    count_d = count_q;
    alarm_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      G_IDLE: begin
        timer_d = '0;
        alarm_d = state_in == ST_ALARM || (state_in == ST_ENTRY && full);
        if (state_in == ST_ENTRY && !full) begin
          state_d = G_OPEN_IN;
          timer_d = T_PASS;
        end else if (state_in == ST_EXIT && count_q != '0) begin
          state_d = G_OPEN_OUT;
          timer_d = T_PASS;
        end
      end
      G_OPEN_IN, G_OPEN_OUT: begin
        if (car_pass) begin
          state_d = state_q == G_OPEN_IN ? G_HOLD_IN : G_HOLD_OUT;
          timer_d = T_HOLD;
          count_d = state_q == G_OPEN_IN ? (full ? count_q : count_q + 1'b1)
                                         : (count_q == '0 ? count_q : count_q - 1'b1);
        end else if (timer_q == '0) begin
          state_d = G_IDLE;
          timer_d = '0;
          tmo_d   = 1'b1;
        end
      end
      default: begin
        if (timer_q == '0) begin
          state_d = G_IDLE;
          timer_d = '0;
        end
      end
    endcase
  end
  // state, timer, count and registered flags; lot_full lags the count register by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= G_IDLE;
      timer_q <= '0;
      count_q <= '0;
      alarm_q <= 1'b0;
      tmo_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      alarm_q <= alarm_d;
      tmo_q   <= tmo_d;
      full_q  <= full;
    end
  end
endmodule

// File: tb/tb_gate_occupancy_ctrl.sv
// tb_gate_occupancy_ctrl: directed scenario bench for gate_occupancy_ctrl
module tb_gate_occupancy_ctrl;
  logic clk = 0, rst = 1, car_pass = 0;
  logic [1:0] state_in = 2'b00;
  logic entry_gate_open, exit_gate_open, alarm, lot_full, busy, timeout_err;
  logic [4:0] count;
  int n_cmp = 0, n_err = 0, exp_cnt = 0;
  int ein, eout, tmo, both;

  gate_occupancy_ctrl dut (
    .clk(clk), .rst(rst), .state_in(state_in), .car_pass(car_pass),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open), .alarm(alarm),
    .count(count), .lot_full(lot_full), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one code, then run the sequence to completion tallying gate-open cycles
  task automatic do_seq(input logic [1:0] code, input int pass_at, input bit toggle,
                        output int e_in, output int e_out, output int t_err, output int b_open);
    int c = 0;
    e_in = 0; e_out = 0; t_err = 0; b_open = 0;
    state_in = code;
    tick();
    state_in = 2'b00;
    while (busy && c < 200) begin
      e_in   += int'(entry_gate_open);
      e_out  += int'(exit_gate_open);
      t_err  += int'(timeout_err);
      b_open += int'(entry_gate_open && exit_gate_open);
      if (toggle) state_in = c[0] ? 2'b01 : 2'b10;
      car_pass = (c == pass_at);
      tick();
      car_pass = 0;
      c++;
    end
    state_in = 2'b00;
    if (c >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL seq_bound: busy still %0d after %0d cycles, required 0", busy, c);
    end
    t_err += int'(timeout_err);
  endtask

  task automatic test_reset();
    #3 rst = 0;
    repeat (2) tick();
    n_cmp++;
    if ({entry_gate_open, exit_gate_open, alarm, lot_full, busy, timeout_err, count} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 0", {entry_gate_open, exit_gate_open, alarm, lot_full, busy, timeout_err, count});
    end
    #4 rst = 1;
    tick();
  endtask

  task automatic test_entry_basic();
    do_seq(2'b01, 3, 0, ein, eout, tmo, both);
    exp_cnt = 1;
    n_cmp++; if (ein !== 12) begin n_err++; $display("FAIL entry_open_cycles: got %0d, required 12", ein); end
    n_cmp++; if (eout !== 0) begin n_err++; $display("FAIL entry_exit_gate: got %0d, required 0", eout); end
    n_cmp++; if (count !== 5'(exp_cnt)) begin n_err++; $display("FAIL entry_count: got %0d, required %0d", count, exp_cnt); end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL entry_timeout: got %0d, required 0", tmo); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL entry_busy_end: got %0d, required 0", busy); end
  endtask

  task automatic test_timeout();
    do_seq(2'b01, -1, 0, ein, eout, tmo, both);
    n_cmp++; if (ein !== 64) begin n_err++; $display("FAIL abort_open_cycles: got %0d, required 64", ein); end
    n_cmp++; if (tmo !== 1) begin n_err++; $display("FAIL abort_timeout_err: got %0d, required 1", tmo); end
    n_cmp++; if (count !== 5'(exp_cnt)) begin n_err++; $display("FAIL abort_count: got %0d, required %0d", count, exp_cnt); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL abort_pulse_width: got %0d, required 0", timeout_err); end
    do_seq(2'b01, 63, 0, ein, eout, tmo, both);
    exp_cnt++;
    n_cmp++; if (ein !== 72) begin n_err++; $display("FAIL last_cycle_open: got %0d, required 72", ein); end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL last_cycle_timeout: got %0d, required 0", tmo); end
    n_cmp++; if (count !== 5'(exp_cnt)) begin n_err++; $display("FAIL last_cycle_count: got %0d, required %0d", count, exp_cnt); end
  endtask

  task automatic test_toggle();
    do_seq(2'b01, 2, 1, ein, eout, tmo, both);
    exp_cnt++;
    n_cmp++; if (ein !== 11) begin n_err++; $display("FAIL toggle_entry_open: got %0d, required 11", ein); end
    n_cmp++; if (eout !== 0) begin n_err++; $display("FAIL toggle_exit_open: got %0d, required 0", eout); end
    n_cmp++; if (both !== 0) begin n_err++; $display("FAIL toggle_both_open: got %0d, required 0", both); end
    n_cmp++; if (count !== 5'(exp_cnt)) begin n_err++; $display("FAIL toggle_count: got %0d, required %0d", count, exp_cnt); end
  endtask

  task automatic test_idle_misc();
    state_in = 2'b11;
    tick();
    state_in = 2'b00;
    n_cmp++; if ({alarm, busy, entry_gate_open, exit_gate_open} !== 4'b1000) begin n_err++; $display("FAIL alarm_code: got %b, required 1000", {alarm, busy, entry_gate_open, exit_gate_open}); end
    tick();
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL alarm_clear: got %0d, required 0", alarm); end
    car_pass = 1;
    tick();
    car_pass = 0;
    tick();
    n_cmp++; if ({count, timeout_err, busy} !== {5'(exp_cnt), 2'b00}) begin n_err++; $display("FAIL idle_car_pass: got %b, required %b", {count, timeout_err, busy}, {5'(exp_cnt), 2'b00}); end
  endtask

  task automatic test_fill();
    while (exp_cnt < 16) begin
      do_seq(2'b01, 0, 0, ein, eout, tmo, both);
      exp_cnt++;
      n_cmp++; if (count !== 5'(exp_cnt) || ein !== 9) begin n_err++; $display("FAIL fill_step: got count %0d open %0d, required %0d and 9", count, ein, exp_cnt); end
    end
    n_cmp++; if (lot_full !== 1'b1) begin n_err++; $display("FAIL fill_lot_full: got %0d, required 1", lot_full); end
    state_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({alarm, busy, entry_gate_open, count} !== {3'b100, 5'd16}) begin n_err++; $display("FAIL full_entry_%0d: got %b, required %b", i, {alarm, busy, entry_gate_open, count}, {3'b100, 5'd16}); end
    end
    state_in = 2'b00;
    tick();
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL full_alarm_clear: got %0d, required 0", alarm); end
  endtask

  task automatic test_exit();
    while (exp_cnt > 0) begin
      do_seq(2'b10, 1, 0, ein, eout, tmo, both);
      exp_cnt--;
      n_cmp++; if (count !== 5'(exp_cnt) || eout !== 10 || ein !== 0) begin n_err++; $display("FAIL exit_step: got count %0d exit %0d entry %0d, required %0d 10 0", count, eout, ein, exp_cnt); end
      n_cmp++; if (lot_full !== 1'b0) begin n_err++; $display("FAIL exit_lot_full: got %0d, required 0", lot_full); end
    end
    state_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({busy, exit_gate_open, alarm, timeout_err, count} !== 9'd0) begin n_err++; $display("FAIL exit_empty_%0d: got %b, required 0", i, {busy, exit_gate_open, alarm, timeout_err, count}); end
    end
    state_in = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    while (exp_cnt < 4) begin
      do_seq(2'b01, 0, 0, ein, eout, tmo, both);
      exp_cnt++;
    end
    state_in = 2'b01;
    tick();
    state_in = 2'b00;
    car_pass = 1;
    tick();
    car_pass = 0;
    tick();
    n_cmp++; if ({count, busy, entry_gate_open} !== {5'd5, 2'b11}) begin n_err++; $display("FAIL pre_reset_hold: got %b, required %b", {count, busy, entry_gate_open}, {5'd5, 2'b11}); end
    #2 rst = 0;
    #1;
    n_cmp++; if ({count, busy, entry_gate_open, exit_gate_open} !== 8'd0) begin n_err++; $display("FAIL async_reset: got %b, required 0", {count, busy, entry_gate_open, exit_gate_open}); end
    #2 rst = 1;
    tick();
    exp_cnt = 0;
    do_seq(2'b01, 3, 0, ein, eout, tmo, both);
    exp_cnt = 1;
    n_cmp++; if (count !== 5'(exp_cnt) || ein !== 12) begin n_err++; $display("FAIL post_reset_entry: got count %0d open %0d, required 1 and 12", count, ein); end
  endtask

  initial begin
    test_reset();
    test_entry_basic();
    test_timeout();
    test_toggle();
    test_idle_misc();
    test_fill();
    test_exit();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
